// File: rtl/cp0_pkg.sv
// Shared constants for the coprocessor-0 block: register numbers, field positions,
// exception codes and the exception handler entry address.
package cp0_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned INT_W  = 6;
  localparam int unsigned CODE_W = 5;

  localparam logic [ADDR_W-1:0] REG_SR    = 5'd12;
  localparam logic [ADDR_W-1:0] REG_CAUSE = 5'd13;
  localparam logic [ADDR_W-1:0] REG_EPC   = 5'd14;
  localparam logic [ADDR_W-1:0] REG_PRID  = 5'd15;

  localparam int unsigned IM_HI   = 15;
  localparam int unsigned IM_LO   = 10;
  localparam int unsigned EXL_BIT = 1;
  localparam int unsigned IE_BIT  = 0;
  localparam int unsigned BD_BIT  = 31;
  localparam int unsigned IP_HI   = 15;
  localparam int unsigned IP_LO   = 10;
  localparam int unsigned EXC_HI  = 6;
  localparam int unsigned EXC_LO  = 2;

  typedef enum logic [CODE_W-1:0] {
    EXC_INT  = 5'd0,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_RI   = 5'd10,
    EXC_OV   = 5'd12
  } exc_code_e;

  localparam logic [DATA_W-1:0] HANDLER_ADDR = 32'h0000_4180;

endpackage

// File: rtl/cp0.sv
// Coprocessor 0: SR/Cause/EPC/PRId storage, interrupt vs. exception arbitration,
// and mfc0/mtc0 service at the M stage.
module cp0
  import cp0_pkg::*;
#(
  parameter logic [31:0] PRID = 32'h2021_0602
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] cp0_addr,
  input  logic [DATA_W-1:0] cp0_wdata,
  output logic [DATA_W-1:0] cp0_rdata,
  input  logic [DATA_W-1:0] vpc,
  input  logic              bd_in,
  input  logic [CODE_W-1:0] exc_code_in,
  input  logic [INT_W-1:0]  hw_int,
  input  logic              eret_m,
  output logic              req,
  output logic [DATA_W-1:0] epc_out
);

  logic [INT_W-1:0]  im;
  logic              exl;
  logic              ie;
  logic              bd;
  logic [INT_W-1:0]  ip;
  logic [CODE_W-1:0] exc_code;
  logic [DATA_W-1:0] epc;

  logic              int_req;
  logic              exc_req;
  logic [DATA_W-1:0] epc_next;
  logic [DATA_W-1:0] sr_word;
  logic [DATA_W-1:0] cause_word;

  // Pending interrupts are judged on the live lines, not the registered IP copy.
  assign int_req = (|(hw_int & im)) & ie & ~exl;
  assign exc_req = (exc_code_in != '0) & ~exl;
  assign req     = int_req | exc_req;

  // Victim in a delay slot restarts at its branch; the low bits are always word-aligned.
  assign epc_next = (bd_in ? (vpc - DATA_W'(4)) : vpc) & ~DATA_W'(3);

  assign sr_word    = {16'b0, im, 8'b0, exl, ie};
  assign cause_word = {bd, 15'b0, ip, 3'b0, exc_code, 2'b0};
  assign epc_out    = epc;

  always_comb begin
    cp0_rdata = '0;
    case (cp0_addr)
      REG_SR:    cp0_rdata = sr_word;
      REG_CAUSE: cp0_rdata = cause_word;
      REG_EPC:   cp0_rdata = epc;
      REG_PRID:  cp0_rdata = PRID;
      default:   cp0_rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      im       <= '0;
      exl      <= 1'b0;
      ie       <= 1'b0;
      bd       <= 1'b0;
      ip       <= '0;
      exc_code <= '0;
      epc      <= '0;
    end else begin
      ip <= hw_int;
      if (req) begin
        exl      <= 1'b1;
        bd       <= bd_in;
        exc_code <= int_req ? EXC_INT : exc_code_in;
        epc      <= epc_next;
      end else begin
        if (we) begin
          case (cp0_addr)
            REG_SR: begin
              im  <= cp0_wdata[IM_HI:IM_LO];
              exl <= cp0_wdata[EXL_BIT];
              ie  <= cp0_wdata[IE_BIT];
            end
            REG_EPC: epc <= cp0_wdata;
            default: ;
          endcase
        end
        // Placed after the SR write so eret's EXL clear takes precedence.
        if (eret_m) exl <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cp0.sv
// Self-checking bench for cp0: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a register-word-level model.
module tb_cp0;

  localparam logic [31:0] PRID_VAL = 32'h2021_0602;

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic [4:0]  cp0_addr;
  logic [31:0] cp0_wdata;
  logic [31:0] cp0_rdata;
  logic [31:0] vpc;
  logic        bd_in;
  logic [4:0]  exc_code_in;
  logic [5:0]  hw_int;
  logic        eret_m;
  logic        req;
  logic [31:0] epc_out;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state kept as whole architectural register words.
  logic [31:0] m_sr, m_cause, m_epc;

  cp0 #(.PRID(PRID_VAL)) dut (
    .clk(clk), .reset(reset), .we(we), .cp0_addr(cp0_addr), .cp0_wdata(cp0_wdata),
    .cp0_rdata(cp0_rdata), .vpc(vpc), .bd_in(bd_in), .exc_code_in(exc_code_in),
    .hw_int(hw_int), .eret_m(eret_m), .req(req), .epc_out(epc_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic m_int_req();
    return (|(hw_int & m_sr[15:10])) && m_sr[0] && !m_sr[1];
  endfunction

  function automatic logic m_req();
    return m_int_req() || ((exc_code_in != 5'd0) && !m_sr[1]);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd12:   return m_sr;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      5'd15:   return PRID_VAL;
      default: return 32'h0;
    endcase
  endfunction

  // Sample mid-cycle and compare every observable output against the model.
  task automatic cyc();
    @(negedge clk);
    chk("model_req", {31'b0, req}, {31'b0, m_req()});
    chk("model_rdata", cp0_rdata, m_read(cp0_addr));
    chk("model_epc_out", epc_out, m_epc);
  endtask

  // Apply the architectural rules for the current inputs, then cross the edge.
  task automatic adv();
    logic [31:0] sr, cause, epc;
    sr = m_sr; cause = m_cause; epc = m_epc;
    if (reset) begin
      sr = 0; cause = 0; epc = 0;
    end else begin
      if (m_req()) begin
        sr[1]      = 1'b1;
        cause[31]  = bd_in;
        cause[6:2] = m_int_req() ? 5'd0 : exc_code_in;
        epc        = bd_in ? vpc - 32'd4 : vpc;
        epc[1:0]   = 2'b00;
      end else begin
        if (we && cp0_addr == 5'd12) sr = cp0_wdata & 32'h0000_FC03;
        if (we && cp0_addr == 5'd14) epc = cp0_wdata;
        if (eret_m) sr[1] = 1'b0;
      end
      cause[15:10] = hw_int;
    end
    @(posedge clk);
    m_sr = sr; m_cause = cause; m_epc = epc;
    #1;
  endtask

  task automatic idle();
    we = 0; cp0_addr = 5'd0; cp0_wdata = 0; vpc = 32'h0000_3000; bd_in = 0;
    exc_code_in = 0; eret_m = 0;
  endtask

  initial begin
    m_sr = 0; m_cause = 0; m_epc = 0;
    idle(); hw_int = 0; reset = 1;
    @(posedge clk); #1;
    adv(); adv();
    reset = 0;

    // Reset state of every mapped register.
    cp0_addr = 5'd12; cyc(); chk("rst_sr", cp0_rdata, 32'h0); chk("rst_req", {31'b0, req}, 32'h0); adv();
    cp0_addr = 5'd13; cyc(); chk("rst_cause", cp0_rdata, 32'h0); adv();
    cp0_addr = 5'd14; cyc(); chk("rst_epc", cp0_rdata, 32'h0); chk("rst_epc_out", epc_out, 32'h0); adv();
    cp0_addr = 5'd15; cyc(); chk("prid", cp0_rdata, PRID_VAL); adv();

    // Enable all interrupt lines, then raise HWInt2.
    we = 1; cp0_addr = 5'd12; cp0_wdata = 32'h0000_FC01; cyc(); adv();
    we = 0; hw_int = 6'b000001; vpc = 32'h0000_1000; cp0_addr = 5'd13;
    cyc(); chk("int_req", {31'b0, req}, 32'h1); adv();

    // Interrupt recorded; EXL now masks both a new exception and the live interrupt.
    exc_code_in = 5'd4;
    cyc(); chk("int_cause", cp0_rdata, 32'h0000_0400); chk("int_epc", epc_out, 32'h0000_1000);
    chk("exl_masks", {31'b0, req}, 32'h0); adv();
    exc_code_in = 0; eret_m = 1; cp0_addr = 5'd12;
    cyc(); chk("int_sr", cp0_rdata, 32'h0000_FC03); chk("eret_cycle_req", {31'b0, req}, 32'h0); adv();
    eret_m = 0; vpc = 32'h0000_1100;
    cyc(); chk("pending_int_fires", {31'b0, req}, 32'h1); adv();
    hw_int = 0; eret_m = 1; cyc(); adv();

    // Overflow in a delay slot.
    eret_m = 0; exc_code_in = 5'd12; bd_in = 1; vpc = 32'h0000_3008;
    cyc(); chk("ov_req", {31'b0, req}, 32'h1); adv();
    exc_code_in = 0; bd_in = 0; cp0_addr = 5'd13; eret_m = 1;
    cyc(); chk("bd_epc", epc_out, 32'h0000_3004); chk("bd_cause", cp0_rdata, 32'h8000_0030); adv();

    // Exception beats a simultaneous mtc0 to EPC.
    eret_m = 0; exc_code_in = 5'd10; we = 1; cp0_addr = 5'd14; cp0_wdata = 32'hDEAD_BEEF;
    vpc = 32'h0000_2000;
    cyc(); chk("ri_req", {31'b0, req}, 32'h1); adv();

    // eret + SR write together: EXL clear wins even though the data sets EXL.
    exc_code_in = 0; eret_m = 1; we = 1; cp0_addr = 5'd12; cp0_wdata = 32'h0000_0002;
    cyc(); chk("ri_epc", epc_out, 32'h0000_2000); adv();
    eret_m = 0; we = 1; cp0_addr = 5'd13; cp0_wdata = 32'hFFFF_FFFF; hw_int = 6'b101010;
    cyc(); chk("sr_after_eret_wr", m_read(5'd12), 32'h0); adv();
    we = 0;
    cyc(); chk("cause_ro", cp0_rdata, 32'h0000_A828); adv();
    cp0_addr = 5'd12; cyc(); chk("sr_eret_wins", cp0_rdata, 32'h0); adv();

    // Reset overrides a concurrent request.
    reset = 1; exc_code_in = 5'd12; vpc = 32'h0000_5000; cyc(); adv();
    reset = 0; exc_code_in = 0; cp0_addr = 5'd14;
    cyc(); chk("rst_over_req_epc", epc_out, 32'h0); chk("rst_over_req_cause", m_read(5'd13), 32'h0); adv();

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      int r;
      reset = ($urandom_range(0, 199) == 0);
      we = ($urandom_range(0, 3) == 0);
      r = $urandom_range(0, 5);
      cp0_addr = (r < 4) ? 5'(12 + r) : 5'($urandom_range(0, 31));
      cp0_wdata = $urandom;
      vpc = $urandom;
      bd_in = $urandom_range(0, 1) == 1;
      eret_m = ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 11))
        0: exc_code_in = 5'd4;
        1: exc_code_in = 5'd5;
        2: exc_code_in = 5'd10;
        3: exc_code_in = 5'd12;
        default: exc_code_in = 5'd0;
      endcase
      hw_int = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0;
      cyc(); adv();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cp0.md
# cp0

Coprocessor-0 block for the five-stage MIPS pipeline. It holds SR, Cause, EPC and PRId, and arbitrates hardware interrupts against synchronous exceptions reported from the M stage. It drives `req` and `epc_out` directly into the PC stage: `req` redirects fetch to 0x0000_4180, and `epc_out` is the `eret` return target. It also serves `mfc0`/`mtc0` at the M stage.

## Interface
Parameters:
- `PRID`, 32'h2021_0602: constant value returned for PRId (register 15).

Ports:
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `we` in 1: `mtc0` write enable (M stage).
- `cp0_addr` in 5: register number for read and write.
- `cp0_wdata` in 32: `mtc0` data.
- `cp0_rdata` out 32: `mfc0` data, combinational.
- `vpc` in 32: PC of the instruction currently in M (macro PC).
- `bd_in` in 1: the M instruction sits in a branch delay slot.
- `exc_code_in` in 5: pending exception code of the M instruction; 0 means none.
- `hw_int` in 6: external interrupt lines HWInt[7:2], level-sensitive.
- `eret_m` in 1: an `eret` is in M.
- `req` out 1: take exception/interrupt this cycle; flushes the pipeline and redirects the PC.
- `epc_out` out 32: current EPC register value.

## Operation
Register bit layouts:
- SR (12): IM = [15:10], EXL = [1], IE = [0]. All other bits read 0.
- Cause (13): BD = [31], IP = [15:10], ExcCode = [6:2]. All other bits read 0.
- EPC (14): 32 bits.
- PRId (15): `PRID`.

Request logic:
- int_req = |(hw_int & SR.IM) & SR.IE & !SR.EXL
- exc_req = (exc_code_in != 0) & !SR.EXL
- req = int_req | exc_req, combinational.
- Interrupt has priority over a simultaneous exception.

Updates on each clock edge when `req`=1:
- EXL <= 1.
- BD <= `bd_in`.
- ExcCode <= 0 if int_req, else `exc_code_in`.
- EPC <= `bd_in` ? `vpc`-4 : `vpc`, with bits [1:0] forced to 0.
- Any `mtc0` and `eret_m` in the same cycle are ignored.

Updates when `req`=0:
- `eret_m` → EXL <= 0.
- `we` → write the target register:
  - SR: only IM/EXL/IE are written.
  - EPC: full 32 bits.
  - Cause and PRId: writes ignored.
  - Other addresses: no effect.
- If `eret_m` and `we` to SR occur together, `eret_m`'s EXL clear wins; IM and IE take the written value.

Every cycle: Cause.IP <= `hw_int`, independent of `req`, `we` and EXL.

Reads: `cp0_rdata` returns the pre-edge register value. Unmapped addresses return 0.

Reset values: SR=0, Cause=0, EPC=0, so `req`=0, `epc_out`=0 and `cp0_rdata`=0 for registers 12–14. Reset overrides everything, including a concurrent `req`.

## Timing
- `req` is combinational, in the same cycle as its inputs. The PC loads 0x4180 on the next edge.
- EPC, EXL, Cause and SR changes become visible one cycle after the edge that commits them.
- `epc_out` is a plain register output with no `mtc0` bypass. The decode-stage stall logic holds `eret` in D while an `mtc0` to EPC is in E or M.
- Back-to-back requests: after one is taken, EXL=1 masks all further `req` until `eret_m` commits.
- An interrupt raised while EXL=1 is recorded in Cause.IP and fires in the first cycle after EXL clears, if IE and IM still allow it.

## Structure
- Shared package `cp0_pkg` holds:
  - Register numbers 12/13/14/15.
  - Bit-position constants for IM, EXL, IE, BD, IP and ExcCode.
  - ExcCode constants: Int=0, AdEL=4, AdES=5, RI=10, Ov=12.
  - The handler address 32'h0000_4180.
- Flat single module; no sub-module.

## Test plan
- Reset, then read registers 12, 13, 14 and 15 → 0, 0, 0 and `PRID`; `req`=0.
- `mtc0` SR=32'h0000_FC01, then `hw_int`=6'b000001 → `req`=1. On the next cycle: Cause=32'h0000_0400 with ExcCode 0, EXL=1, EPC=`vpc`.
- `exc_code_in`=12 with `bd_in`=1 and `vpc`=32'h3008 → `req`=1; then EPC=32'h3004, Cause.BD=1, ExcCode=12.
- With EXL=1, assert `exc_code_in`=4 and `hw_int` → `req` stays 0. `eret_m` → EXL=0 next cycle, then `req` rises for the still-pending interrupt.
- Same cycle: `exc_code_in`=10 and `we` to EPC=32'hDEAD_BEEF → EPC takes the exception value and the write is dropped.
- `mtc0` to Cause=32'hFFFF_FFFF → Cause unchanged except IP tracking `hw_int`.
